// File: rtl/frame_config_sequencer.sv
// Frame-based configuration sequencer: turns a header+rows word stream into a
// FrameData image and a single-cycle-per-slot FrameStrobe commit pulse.
module frame_config_sequencer #(
  parameter int NumRows         = 4,
  parameter int NumColumns      = 4,
  parameter int MaxFramesPerCol = 32,
  parameter int FrameBitsPerRow = 32,
  parameter int StrobeCycles    = 1
) (
  input  logic                                   UserCLK,
  input  logic                                   reset,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [31:0]                            cfg_data,
  output logic [NumRows*FrameBitsPerRow-1:0]     FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   cfg_error,
  output logic [15:0]                            frame_count
);

  localparam int StrobeBits = NumColumns * MaxFramesPerCol;
  localparam int AddrW      = (StrobeBits > 1) ? $clog2(StrobeBits) : 1;
  localparam int RowW       = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RowW-1:0] LastRow    = RowW'(NumRows - 1);
  localparam logic [3:0]      LastStrobe = 4'(StrobeCycles - 1);
  localparam logic [31:0]     NumColsW   = 32'(NumColumns);
  localparam logic [31:0]     MaxFrmW    = 32'(MaxFramesPerCol);
  localparam logic [7:0]      SyncByte   = 8'hFA;

  typedef enum logic [2:0] {
    S_HEADER,
    S_LOAD,
    S_DISCARD,
    S_STROBE,
    S_HOLD
  } state_e;

  state_e                                state_q, state_d;
  logic [RowW-1:0]                       row_cnt_q, row_cnt_d;
  logic [AddrW-1:0]                      addr_q, addr_d;
  logic [3:0]                            strobe_cnt_q, strobe_cnt_d;
  logic [NumRows*FrameBitsPerRow-1:0]    frame_data_q, frame_data_d;
  logic [StrobeBits-1:0]                 frame_strobe_q, frame_strobe_d;
  logic                                  frame_done_q, frame_done_d;
  logic                                  cfg_error_q, cfg_error_d;
  logic [15:0]                           frame_count_q, frame_count_d;

  logic        transfer;
  logic [31:0] hdr_col;
  logic [31:0] hdr_frm;

  assign cfg_ready = (state_q == S_HEADER) || (state_q == S_LOAD) || (state_q == S_DISCARD);
  assign busy      = (state_q != S_HEADER);
  assign transfer  = cfg_valid && cfg_ready;
  assign hdr_col   = {24'd0, cfg_data[15:8]};
  assign hdr_frm   = {27'd0, cfg_data[4:0]};

  always_comb begin
    state_d       = state_q;
    row_cnt_d     = row_cnt_q;
    addr_d        = addr_q;
    strobe_cnt_d  = strobe_cnt_q;
    frame_data_d  = frame_data_q;
    frame_done_d  = 1'b0;
    cfg_error_d   = cfg_error_q;
    frame_count_d = frame_count_q;

    case (state_q)
      S_HEADER: begin
        if (transfer) begin
          if (cfg_data[31:24] != SyncByte) begin
            cfg_error_d = 1'b1;
          end else if ((hdr_col < NumColsW) && (hdr_frm < MaxFrmW)) begin
            addr_d    = AddrW'(hdr_col * MaxFrmW + hdr_frm);
            row_cnt_d = '0;
            state_d   = S_LOAD;
          end else begin
            cfg_error_d = 1'b1;
            row_cnt_d   = '0;
            state_d     = S_DISCARD;
          end
        end
      end
      S_LOAD: begin
        if (transfer) begin
          for (int r = 0; r < NumRows; r++) begin
            if (row_cnt_q == RowW'(r)) begin
              frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = cfg_data;
            end
          end
          if (row_cnt_q == LastRow) begin
            strobe_cnt_d = '0;
            state_d      = S_STROBE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      S_DISCARD: begin
        if (transfer) begin
          if (row_cnt_q == LastRow) begin
            state_d = S_HEADER;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      S_STROBE: begin
        if (strobe_cnt_q == LastStrobe) begin
          state_d       = S_HOLD;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          strobe_cnt_d = strobe_cnt_q + 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_HEADER;
      end
      default: begin
        state_d = S_HEADER;
      end
    endcase
  end

  // Strobe is registered on entry to STROBE so it lines up with the state register.
  for (genvar gi = 0; gi < StrobeBits; gi++) begin : g_strobe
    assign frame_strobe_d[gi] = (state_d == S_STROBE) && (addr_d == AddrW'(gi));
  end

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state_q        <= S_HEADER;
      row_cnt_q      <= '0;
      addr_q         <= '0;
      strobe_cnt_q   <= '0;
      frame_data_q   <= '0;
      frame_strobe_q <= '0;
      frame_done_q   <= 1'b0;
      cfg_error_q    <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      row_cnt_q      <= row_cnt_d;
      addr_q         <= addr_d;
      strobe_cnt_q   <= strobe_cnt_d;
      frame_data_q   <= frame_data_d;
      frame_strobe_q <= frame_strobe_d;
      frame_done_q   <= frame_done_d;
      cfg_error_q    <= cfg_error_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign FrameData   = frame_data_q;
  assign FrameStrobe = frame_strobe_q;
  assign frame_done  = frame_done_q;
  assign cfg_error   = cfg_error_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench: one instance with StrobeCycles=1, one with StrobeCycles=3 for the stall case.
module tb_frame_config_sequencer;

  logic         UserCLK = 1'b0;
  logic         reset = 1'b1;
  logic         cfg_valid = 1'b0, cfg_valid3 = 1'b0;
  logic [31:0]  cfg_data = '0, cfg_data3 = '0;
  logic         cfg_ready, cfg_ready3;
  logic [127:0] FrameData, FrameData3;
  logic [127:0] FrameStrobe, FrameStrobe3;
  logic         busy, busy3, frame_done, frame_done3, cfg_error, cfg_error3;
  logic [15:0]  frame_count, frame_count3;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] ONE = 128'd1;
  localparam logic [127:0] BASIC_DATA = 128'h44444444_33333333_22222222_11111111;

  always #5 UserCLK = ~UserCLK;

  frame_config_sequencer #(.StrobeCycles(1)) dut (
    .UserCLK(UserCLK), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy),
    .frame_done(frame_done), .cfg_error(cfg_error), .frame_count(frame_count)
  );

  frame_config_sequencer #(.StrobeCycles(3)) dut3 (
    .UserCLK(UserCLK), .reset(reset), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_data(cfg_data3), .FrameData(FrameData3), .FrameStrobe(FrameStrobe3), .busy(busy3),
    .frame_done(frame_done3), .cfg_error(cfg_error3), .frame_count(frame_count3)
  );

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cfg_valid = 1'b0; cfg_valid3 = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (FrameData !== 128'd0) begin errors++; $display("FAIL reset_framedata: got %h expected 0", FrameData); end
    checks++; if (FrameStrobe !== 128'd0) begin errors++; $display("FAIL reset_strobe: got %h expected 0", FrameStrobe); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", cfg_error); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
    checks++; if (cfg_ready3 !== 1'b1 || FrameStrobe3 !== 128'd0) begin errors++; $display("FAIL reset_dut3: ready %b strobe %h expected 1 and 0", cfg_ready3, FrameStrobe3); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] rows [4];
    rows[0] = 32'h11111111; rows[1] = 32'h22222222; rows[2] = 32'h33333333; rows[3] = 32'h44444444;
    cfg_valid = 1'b1; cfg_data = 32'hFA000203;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_load: got %b expected 1", busy); end
    for (int i = 0; i < 4; i++) begin
      cfg_data = rows[i];
      if (i == 3) begin
        checks++; if (FrameStrobe !== 128'd0) begin errors++; $display("FAIL basic_early_strobe: got %h expected 0", FrameStrobe); end
      end
      step();
    end
    cfg_valid = 1'b0;
    checks++; if (FrameData !== BASIC_DATA) begin errors++; $display("FAIL basic_data: got %h expected %h", FrameData, BASIC_DATA); end
    checks++; if (FrameStrobe !== (ONE << 67)) begin errors++; $display("FAIL basic_strobe: got %h expected %h", FrameStrobe, ONE << 67); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_strobe: got %b expected 0", cfg_ready); end
    step();
    checks++; if (FrameStrobe !== 128'd0) begin errors++; $display("FAIL basic_strobe_fall: got %h expected 0", FrameStrobe); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", frame_done); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", frame_count); end
    checks++; if (FrameData !== BASIC_DATA) begin errors++; $display("FAIL basic_hold_data: got %h expected %h", FrameData, BASIC_DATA); end
    step();
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL basic_idle: done %b busy %b ready %b expected 0 0 1", frame_done, busy, cfg_ready); end
    $display("test_basic done: count=%0d", frame_count);
  endtask

  task automatic test_out_of_range();
    cfg_valid = 1'b1; cfg_data = 32'hFA000500;
    step();
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL oor_error: got %b expected 1", cfg_error); end
    checks++; if (busy !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL oor_discard: busy %b ready %b expected 1 1", busy, cfg_ready); end
    for (int i = 0; i < 4; i++) begin
      cfg_data = 32'hDEAD0000 | 32'(i);
      step();
      checks++; if (FrameStrobe !== 128'd0) begin errors++; $display("FAIL oor_strobe: got %h expected 0", FrameStrobe); end
    end
    cfg_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oor_back_header: busy %b expected 0", busy); end
    checks++; if (FrameData !== BASIC_DATA) begin errors++; $display("FAIL oor_data: got %h expected %h", FrameData, BASIC_DATA); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL oor_count: got %0d expected 1", frame_count); end
    step();
    checks++; if (frame_done !== 1'b0 || FrameStrobe !== 128'd0) begin errors++; $display("FAIL oor_no_commit: done %b strobe %h expected 0 0", frame_done, FrameStrobe); end
    $display("test_out_of_range done");
  endtask

  task automatic test_bad_sync();
    do_reset();
    cfg_valid = 1'b1; cfg_data = 32'hAB000000;
    step();
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL sync_error: got %b expected 1", cfg_error); end
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL sync_header: busy %b ready %b expected 0 1", busy, cfg_ready); end
    cfg_data = 32'hFA000100;
    step();
    for (int i = 0; i < 4; i++) begin
      cfg_data = 32'h55555555 + 32'(i) * 32'h11111111;
      step();
    end
    cfg_valid = 1'b0;
    checks++; if (FrameStrobe !== (ONE << 32)) begin errors++; $display("FAIL sync_strobe: got %h expected %h", FrameStrobe, ONE << 32); end
    step();
    checks++; if (frame_done !== 1'b1 || frame_count !== 16'd1) begin errors++; $display("FAIL sync_commit: done %b count %0d expected 1 1", frame_done, frame_count); end
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL sync_sticky: got %b expected 1", cfg_error); end
    checks++; if (FrameData !== 128'h88888888_77777777_66666666_55555555) begin errors++; $display("FAIL sync_data: got %h expected 88888888777777776666666655555555", FrameData); end
    step();
    $display("test_bad_sync done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_valid = 1'b1; cfg_data = 32'hFA000302;
    step();
    cfg_data = 32'hAAAA0001; step();
    cfg_data = 32'hAAAA0002; step();
    checks++; if (FrameData[63:0] !== {32'hAAAA0002, 32'hAAAA0001}) begin errors++; $display("FAIL mid_partial: got %h expected AAAA0002AAAA0001", FrameData[63:0]); end
    reset = 1'b1; cfg_data = 32'hAAAA0003;
    step();
    reset = 1'b0; cfg_valid = 1'b0;
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_header: busy %b ready %b expected 0 1", busy, cfg_ready); end
    checks++; if (FrameData !== 128'd0) begin errors++; $display("FAIL mid_data: got %h expected 0", FrameData); end
    step(); step();
    checks++; if (FrameStrobe !== 128'd0 || frame_count !== 16'd0) begin errors++; $display("FAIL mid_no_strobe: strobe %h count %0d expected 0 0", FrameStrobe, frame_count); end
    cfg_valid = 1'b1; cfg_data = 32'hFA000302;
    step();
    for (int i = 0; i < 4; i++) begin
      cfg_data = 32'hBBBB0000 | 32'(i);
      step();
    end
    cfg_valid = 1'b0;
    checks++; if (FrameStrobe !== (ONE << 98)) begin errors++; $display("FAIL mid_recover_strobe: got %h expected %h", FrameStrobe, ONE << 98); end
    step();
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL mid_recover_count: got %0d expected 1", frame_count); end
    step();
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    logic [31:0]  words [15];
    logic [127:0] sval [3];
    int           scyc [3];
    int           n = 0;
    int           idx = 0;
    logic         adv;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      words[p*5] = {8'hFA, 8'h00, 8'(p), 8'(p)};
      for (int r = 0; r < 4; r++) words[p*5+1+r] = {4'(p+1), 28'(r)};
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (idx < 15) begin cfg_valid = 1'b1; cfg_data = words[idx]; end
      else cfg_valid = 1'b0;
      adv = cfg_valid && cfg_ready;
      step();
      if (adv) idx++;
      if (FrameStrobe != 128'd0) begin
        if (n < 3) begin scyc[n] = cyc; sval[n] = FrameStrobe; end
        n++;
      end
    end
    cfg_valid = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_strobe_cycles: got %0d expected 3", n); end
    if (n >= 3) begin
      checks++; if (scyc[0] !== 4) begin errors++; $display("FAIL b2b_first: got cycle %0d expected 4", scyc[0]); end
      checks++; if (scyc[1] - scyc[0] !== 7) begin errors++; $display("FAIL b2b_gap1: got %0d expected 7", scyc[1] - scyc[0]); end
      checks++; if (scyc[2] - scyc[1] !== 7) begin errors++; $display("FAIL b2b_gap2: got %0d expected 7", scyc[2] - scyc[1]); end
      checks++; if (sval[0] !== ONE || sval[1] !== (ONE << 33) || sval[2] !== (ONE << 66)) begin errors++; $display("FAIL b2b_bits: got %h %h %h expected bits 0 33 66", sval[0], sval[1], sval[2]); end
    end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", frame_count); end
    checks++; if (FrameData !== 128'h30000003_30000002_30000001_30000000) begin errors++; $display("FAIL b2b_data: got %h expected 30000003300000023000000130000000", FrameData); end
    $display("test_back_to_back done: strobes=%0d", n);
  endtask

  task automatic test_stall();
    do_reset();
    cfg_valid3 = 1'b1; cfg_data3 = 32'hFA000107;
    step();
    for (int r = 0; r < 4; r++) begin
      cfg_valid3 = 1'b0;
      step();
      checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", busy3); end
      cfg_valid3 = 1'b1; cfg_data3 = 32'hC0000000 | 32'(r);
      if (r == 3) begin
        checks++; if (FrameStrobe3 !== 128'd0) begin errors++; $display("FAIL stall_early_strobe: got %h expected 0", FrameStrobe3); end
      end
      step();
      if (r == 1) begin
        checks++; if (FrameData3[63:0] !== {32'hC0000001, 32'hC0000000}) begin errors++; $display("FAIL stall_partial: got %h expected C0000001C0000000", FrameData3[63:0]); end
      end
    end
    cfg_data3 = 32'hFA000000;
    for (int k = 0; k < 3; k++) begin
      checks++; if (FrameStrobe3 !== (ONE << 39)) begin errors++; $display("FAIL stall_strobe_%0d: got %h expected %h", k, FrameStrobe3, ONE << 39); end
      checks++; if (cfg_ready3 !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d: got %b expected 0", k, cfg_ready3); end
      step();
    end
    checks++; if (FrameStrobe3 !== 128'd0 || frame_done3 !== 1'b1) begin errors++; $display("FAIL stall_hold: strobe %h done %b expected 0 1", FrameStrobe3, frame_done3); end
    checks++; if (cfg_ready3 !== 1'b0) begin errors++; $display("FAIL stall_hold_ready: got %b expected 0", cfg_ready3); end
    checks++; if (frame_count3 !== 16'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", frame_count3); end
    checks++; if (FrameData3 !== 128'hC0000003_C0000002_C0000001_C0000000) begin errors++; $display("FAIL stall_data: got %h expected C0000003C0000002C0000001C0000000", FrameData3); end
    cfg_valid3 = 1'b0;
    step();
    checks++; if (cfg_ready3 !== 1'b1 || busy3 !== 1'b0 || frame_done3 !== 1'b0) begin errors++; $display("FAIL stall_idle: ready %b busy %b done %b expected 1 0 0", cfg_ready3, busy3, frame_done3); end
    $display("test_stall done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_of_range();
    test_bad_sync();
    test_reset_mid();
    test_back_to_back();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_config_sequencer.md
# frame_config_sequencer

Configuration frame sequencer for the fabric's frame-based configuration network. It accepts a 32-bit configuration word stream over a valid/ready handshake and assembles one full frame, one word per tile row. It drives the assembled frame onto the fabric's `FrameData` bus, which is daisy-chained through each tile row. It then pulses exactly one `FrameStrobe` bit to commit the frame into the addressed column and frame slot.

## Interface

- `NumRows`, 4: tile rows per column; words per frame.
- `NumColumns`, 4: fabric columns.
- `MaxFramesPerCol`, 32: frame slots per column.
- `FrameBitsPerRow`, 32: `FrameData` bits per row. Must be 32 (one stream word per row).
- `StrobeCycles`, 1: strobe width in cycles, 1..15.

Ports:

- `UserCLK` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `cfg_valid` input 1: stream word valid.
- `cfg_ready` output 1: sequencer accepts a word.
- `cfg_data` input 32: stream word.
- `FrameData` output `NumRows*FrameBitsPerRow`: row r occupies bits `[r*32 +: 32]`.
- `FrameStrobe` output `NumColumns*MaxFramesPerCol`: column c, frame f maps to bit `c*MaxFramesPerCol+f`.
- `busy` output 1: high in any state other than HEADER.
- `frame_done` output 1: one-cycle pulse when a frame commit completes.
- `cfg_error` output 1: sticky error flag, cleared only by `reset`.
- `frame_count` output 16: number of committed frames. Wraps from 0xFFFF to 0.

## Operation

- Transfer rule: a word transfers when `cfg_valid && cfg_ready` on a rising edge.
- Packet format: one header word, then `NumRows` data words, row 0 first.
  - Header `[31:24]` is the sync byte and must equal 0xFA.
  - Header `[15:8]` is the column index.
  - Header `[4:0]` is the frame index.
  - All other header bits are ignored.
- State HEADER (`cfg_ready`=1):
  - Sync byte mismatch: drop the word, set `cfg_error`, stay in HEADER.
  - Sync OK, column < `NumColumns` and frame < `MaxFramesPerCol`: latch the address, clear the row counter, go to LOAD.
  - Sync OK but column or frame out of range: set `cfg_error`, go to DISCARD.
- State LOAD (`cfg_ready`=1):
  - Each transfer writes `cfg_data` into `FrameData` row `row_cnt`, then increments `row_cnt`.
  - On the transfer of row `NumRows-1`, go to STROBE.
- State DISCARD (`cfg_ready`=1):
  - Consumes `NumRows` words without touching `FrameData`, then returns to HEADER.
  - No strobe, no `frame_done`, no count increment.
- State STROBE (`cfg_ready`=0):
  - The addressed `FrameStrobe` bit is 1; all other bits are 0.
  - Stays for exactly `StrobeCycles` cycles, then goes to HOLD.
- State HOLD (`cfg_ready`=0):
  - One cycle with `FrameStrobe` all 0 and `FrameData` unchanged.
  - `frame_done` is 1 in this cycle, and `frame_count` increments.
  - Next state is HEADER.
- Data stability: `FrameData` changes only on LOAD transfers. It holds its value in all other states, including across packets.
- Reset: any state returns to HEADER on the next edge when `reset`=1. A partially loaded frame is abandoned and no strobe is issued. `FrameStrobe` goes to 0 on that same edge.

## Timing

- Reset values: `FrameData`=0, `FrameStrobe`=0, `cfg_ready`=1, `busy`=0, `frame_done`=0, `cfg_error`=0, `frame_count`=0, state=HEADER.
- All outputs are registered. `cfg_ready` is decoded from the state register and never depends combinationally on `cfg_valid`.
- Setup margin: `FrameData` for the last row is stable at least 1 cycle before `FrameStrobe` rises. Implement this as a LOAD→STROBE registered transition: the last row is written at edge N, and the strobe rises at edge N+1.
- Hold margin: `FrameData` is stable for at least 1 cycle after `FrameStrobe` falls (the HOLD state).
- Latency at full throughput (valid held high):
  - Header accepted at edge 0.
  - Rows accepted at edges 1..`NumRows`.
  - Strobe high for edges `NumRows+1` .. `NumRows+StrobeCycles`.
  - HOLD/`frame_done` at edge `NumRows+StrobeCycles+1`.
  - Next header accepted at edge `NumRows+StrobeCycles+2`.
- Back-to-back frames: period is `NumRows+StrobeCycles+2` cycles.
- Stalls: `cfg_valid` low during LOAD or DISCARD stalls indefinitely with no timeout. State and row counter are held.

## Test plan

- Basic commit (defaults):
  - Stimulus: header 0xFA000203, then rows 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Response: `FrameData` = 0x44444444_33333333_22222222_11111111.
  - Only `FrameStrobe[2*32+3]`=`FrameStrobe[67]` is high, for 1 cycle, exactly 1 cycle after row 3 is accepted.
  - `frame_done` pulses once and `frame_count`=1.
- Bad sync:
  - Stimulus: header 0xAB000000.
  - Response: word consumed, `cfg_error`=1, state stays HEADER.
  - A following valid packet still commits normally and `cfg_error` stays 1.
- Out-of-range address:
  - Stimulus: header 0xFA000500 (column 5 ≥ 4).
  - Response: 4 data words consumed, `FrameData` unchanged, `FrameStrobe` all 0, `frame_count` unchanged, `cfg_error`=1.
- Stalls:
  - Stimulus: `cfg_valid` toggling 1/0 during LOAD, and `StrobeCycles`=3.
  - Response: rows land in order. Strobe is high exactly 3 cycles. `cfg_ready`=0 for 4 cycles (STROBE+HOLD) even with `cfg_valid`=1.
- Reset mid-frame:
  - Stimulus: assert `reset` after 2 rows are loaded.
  - Response: next edge gives state HEADER, `FrameData`=0, no strobe, `frame_count`=0.
  - A new packet then commits normally.
- Back-to-back frames:
  - Stimulus: 3 consecutive packets with valid held high.
  - Response: strobes are 7 cycles apart (`NumRows`=4, `StrobeCycles`=1), `frame_count`=3.
